fft_stream_framer: RTL and testbench
====================================

Name: fft_stream_framer

Overview:
Streaming framer placed in front of fft_int. It takes a raw complex sample stream with a valid/ready handshake and emits fft_int-compatible packets with sink-side sop/eop/valid framing. Generalises the fixed 2**POW framing to a runtime-selectable length, downstream backpressure, zero-pad flush, and a round-robin channel tag for an FFT shared across several channels.

Parameters:
DATA_WIDTH, 14, width of each real/imag sample
POW_MIN, 6, smallest allowed frame length exponent
POW_MAX, 12, largest allowed frame length exponent (counter width = POW_MAX)
CHANNELS, 1, number of channels tagged round-robin per frame (1..16)

Ports:
clk  in  1  processing clock
aclr_n  in  1  asynchronous active-low reset
pow_sel  in  4  requested frame length exponent, N = 2**pow_sel
flush  in  1  high: terminate current frame early by zero-padding
in_valid  in  1  input sample valid
in_ready  out  1  framer accepts sample this cycle
in_Re  in  DATA_WIDTH  signed real input
in_Im  in  DATA_WIDTH  signed imaginary input
source_sop  out  1  first sample of frame
source_eop  out  1  last sample of frame
source_valid  out  1  output sample valid
source_ready  in  1  downstream accepts output this cycle
source_Re  out  DATA_WIDTH  signed real output
source_Im  out  DATA_WIDTH  signed imaginary output
source_channel  out  4  channel tag of current frame
error  out  1  one-cycle pulse on illegal pow_sel

Behaviour:
- Reset (aclr_n low, async): source_valid/sop/eop=0, source_Re/Im=0, source_channel=0, error=0, in_ready=0, state IDLE, sample counter 0, skid empty. Reset mid-frame discards the partial frame. After release, the next accepted sample carries sop and channel 0.
- Transfer rules: input transfer occurs when in_valid && in_ready. Output transfer occurs when source_valid && source_ready. Output holds all fields stable while source_valid && !source_ready.
- Pipeline: one output register plus one-entry skid buffer. Latency is 1 cycle from input transfer to source_valid. in_ready = !skid_full (registered). Sustains one sample per cycle with source_ready constantly high.
- States:
  - IDLE: in_ready per skid. On first input transfer, latch N from pow_sel, go to RUN, emit sample with sop=1, counter=1.
  - RUN: each input transfer increments the counter. The sample at counter==N-1 carries eop=1; then channel advances and state returns to IDLE.
  - N==1 does not occur (POW_MIN>=1).
- pow_sel is sampled only at frame start; changes mid-frame have no effect.
- pow_sel outside [POW_MIN,POW_MAX] at frame start: clamp to nearest bound and pulse error for 1 cycle, aligned with the sop sample.
- flush:
  - In RUN: go to PAD next cycle and drop in_ready to 0. Emit zero samples (Re=Im=0, valid=1, respecting source_ready) until counter reaches N-1. The last zero carries eop; then go to IDLE.
  - In IDLE or PAD: ignored.
  - Coinciding with the input transfer that completes the frame (eop sample): no padding, normal eop.
- Channel: increments on the output transfer of each eop sample, wrapping CHANNELS-1 -> 0. Constant 0 when CHANNELS=1. The tag is stable for the whole frame.
- Simultaneous events:
  - eop output transfer and new input transfer in the same cycle: the new sample becomes the next frame's sop with the incremented channel.
  - Backpressure while skid full: in_ready=0 and no input is lost.
- Counter width POW_MAX bits. Counter and framing are independent of data values.

Test Plan:
- pow_sel=6, continuous in_valid, source_ready=1, ramp data 0..127 -> two frames of 64 samples. sop on samples 0 and 64, eop on 63 and 127, data unchanged, 1-cycle latency.
- pow_sel=12, 4096-sample 1 MHz sine at 20.48 MHz clock into fft_int chain -> single frame, eop on sample 4095, fft_int error stays 0.
- CHANNELS=3, pow_sel=6, 7 frames -> source_channel sequence 0,1,2,0,1,2,0.
- pow_sel=6, flush asserted after sample 20 accepted -> in_ready low, 43 zero samples follow, eop on sample 63, next frame starts with sop.
- source_ready toggled 1010..., pow_sel=6 -> all 64 samples in order, no drops/duplicates, in_ready throttles, outputs stable while stalled.
- pow_sel=15 at frame start -> error pulse with sop, frame length 4096. Then aclr_n low at sample 100 -> outputs 0 immediately; after release first sample has sop and channel 0.

Source files
------------

// File: rtl/fft_stream_framer.sv
// Streaming framer ahead of fft_int: cuts a valid/ready sample stream into 2**pow_sel packets
// with sop/eop framing, zero-pad flush, round-robin channel tag and a one-entry skid buffer.
module fft_stream_framer #(
    parameter int DATA_WIDTH = 14,
    parameter int POW_MIN    = 6,
    parameter int POW_MAX    = 12,
    parameter int CHANNELS   = 1
) (
    input  logic                         clk,
    input  logic                         aclr_n,
    input  logic [3:0]                   pow_sel,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_Re,
    input  logic signed [DATA_WIDTH-1:0] in_Im,
    output logic                         source_sop,
    output logic                         source_eop,
    output logic                         source_valid,
    input  logic                         source_ready,
    output logic signed [DATA_WIDTH-1:0] source_Re,
    output logic signed [DATA_WIDTH-1:0] source_Im,
    output logic [3:0]                   source_channel,
    output logic                         error
);

    localparam int CW = POW_MAX;
    localparam logic [1:0]    S_IDLE   = 2'd0;
    localparam logic [1:0]    S_RUN    = 2'd1;
    localparam logic [1:0]    S_PAD    = 2'd2;
    localparam logic [3:0]    P_MIN    = 4'(POW_MIN);
    localparam logic [3:0]    P_MAX    = 4'(POW_MAX);
    localparam logic [3:0]    CH_LAST  = 4'(CHANNELS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]                   r_state;
    logic [CW-1:0]                r_cnt;
    logic [CW-1:0]                r_nm1;
    logic                         r_in_ready;
    logic                         r_out_valid;
    logic                         r_out_sop;
    logic                         r_out_eop;
    logic signed [DATA_WIDTH-1:0] r_out_re;
    logic signed [DATA_WIDTH-1:0] r_out_im;
    logic                         r_skid_full;
    logic                         r_skid_sop;
    logic                         r_skid_eop;
    logic                         r_skid_err;
    logic signed [DATA_WIDTH-1:0] r_skid_re;
    logic signed [DATA_WIDTH-1:0] r_skid_im;
    logic [3:0]                   r_chan;
    logic                         r_error;

    logic                         w_in_xfer;
    logic                         w_out_xfer;
    logic                         w_out_free;
    logic                         w_skid_pop;
    logic                         w_skid_fill;
    logic                         w_skid_full_nxt;
    logic                         w_pow_bad;
    logic [3:0]                   w_pow_eff;
    logic [CW-1:0]                w_nm1_new;
    logic                         w_push;
    logic                         w_push_sop;
    logic                         w_push_eop;
    logic                         w_push_err;
    logic signed [DATA_WIDTH-1:0] w_push_re;
    logic signed [DATA_WIDTH-1:0] w_push_im;
    logic [1:0]                   w_state_nxt;
    logic [CW-1:0]                w_cnt_nxt;
    logic [CW-1:0]                w_nm1_nxt;

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && source_ready;
    assign w_out_free = !r_out_valid || w_out_xfer;

    // Out-of-range exponents are clamped; the flag rides along with the sop sample.
    assign w_pow_bad = (pow_sel < P_MIN) || (pow_sel > P_MAX);
    assign w_pow_eff = (pow_sel < P_MIN) ? P_MIN : ((pow_sel > P_MAX) ? P_MAX : pow_sel);
    assign w_nm1_new = CW'((32'd1 << w_pow_eff) - 32'd1);

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_push      = 1'b0;
        w_push_sop  = 1'b0;
        w_push_eop  = 1'b0;
        w_push_err  = 1'b0;
        w_push_re   = in_Re;
        w_push_im   = in_Im;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_nm1_nxt   = r_nm1;
        case (r_state)
            S_IDLE: begin
                if (w_in_xfer) begin
                    w_push      = 1'b1;
                    w_push_sop  = 1'b1;
                    w_push_err  = w_pow_bad;
                    w_nm1_nxt   = w_nm1_new;
                    w_cnt_nxt   = CNT_ONE;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_in_xfer) begin
                    w_push     = 1'b1;
                    w_push_eop = (r_cnt == r_nm1);
                    if (w_push_eop) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                        if (flush) w_state_nxt = S_PAD;
                    end
                end else if (flush) begin
                    w_state_nxt = S_PAD;
                end
            end
            S_PAD: begin
                w_push_re = '0;
                w_push_im = '0;
                if (!r_skid_full) begin
                    w_push     = 1'b1;
                    w_push_eop = (r_cnt == r_nm1);
                    if (w_push_eop) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A push only happens while the skid is empty, so skid pop and push never coincide.
    assign w_skid_pop      = r_skid_full && w_out_free;
    assign w_skid_fill     = w_push && !w_out_free;
    assign w_skid_full_nxt = (r_skid_full && !w_out_free) || w_skid_fill;

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_nm1       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_skid_full <= 1'b0;
            r_skid_sop  <= 1'b0;
            r_skid_eop  <= 1'b0;
            r_skid_err  <= 1'b0;
            r_skid_re   <= '0;
            r_skid_im   <= '0;
            r_chan      <= '0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_nm1       <= w_nm1_nxt;
            r_in_ready  <= !w_skid_full_nxt && (w_state_nxt != S_PAD);
            r_skid_full <= w_skid_full_nxt;
            r_error     <= (w_push && w_out_free && w_push_err) || (w_skid_pop && r_skid_err);

            if (w_skid_pop) begin
                r_out_valid <= 1'b1;
                r_out_sop   <= r_skid_sop;
                r_out_eop   <= r_skid_eop;
                r_out_re    <= r_skid_re;
                r_out_im    <= r_skid_im;
            end else if (w_push && w_out_free) begin
                r_out_valid <= 1'b1;
                r_out_sop   <= w_push_sop;
                r_out_eop   <= w_push_eop;
                r_out_re    <= w_push_re;
                r_out_im    <= w_push_im;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end

            if (w_skid_fill) begin
                r_skid_sop <= w_push_sop;
                r_skid_eop <= w_push_eop;
                r_skid_err <= w_push_err;
                r_skid_re  <= w_push_re;
                r_skid_im  <= w_push_im;
            end

            // The tag advances only once the eop sample has left, keeping it frame-stable.
            if (w_out_xfer && r_out_eop) begin
                r_chan <= (r_chan == CH_LAST) ? 4'd0 : r_chan + 4'd1;
            end
        end
    end

    assign in_ready       = r_in_ready;
    assign source_valid   = r_out_valid;
    assign source_sop     = r_out_sop;
    assign source_eop     = r_out_eop;
    assign source_Re      = r_out_re;
    assign source_Im      = r_out_im;
    assign source_channel = r_chan;
    assign error          = r_error;

endmodule

// File: tb/tb_fft_stream_framer.sv
// Directed bench for fft_stream_framer: table of frame scenarios plus hand-written reset sequence.
module tb_fft_stream_framer;

    localparam int DW = 14;
    localparam int CH = 3;

    logic                 clk = 1'b0;
    logic                 aclr_n;
    logic [3:0]           pow_sel;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_Re;
    logic signed [DW-1:0] in_Im;
    logic                 source_sop;
    logic                 source_eop;
    logic                 source_valid;
    logic                 source_ready;
    logic signed [DW-1:0] source_Re;
    logic signed [DW-1:0] source_Im;
    logic [3:0]           source_channel;
    logic                 error;

    fft_stream_framer #(
        .DATA_WIDTH(DW),
        .POW_MIN   (6),
        .POW_MAX   (12),
        .CHANNELS  (CH)
    ) dut (
        .clk           (clk),
        .aclr_n        (aclr_n),
        .pow_sel       (pow_sel),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_Re         (in_Re),
        .in_Im         (in_Im),
        .source_sop    (source_sop),
        .source_eop    (source_eop),
        .source_valid  (source_valid),
        .source_ready  (source_ready),
        .source_Re     (source_Re),
        .source_Im     (source_Im),
        .source_channel(source_channel),
        .error         (error)
    );

    always #5 clk = ~clk;

    // fmode: 0 = no flush, 1 = flush the cycle after sample fidx is accepted, 2 = flush alongside sample fidx
    typedef struct {
        int pow;
        int pow_mid;
        int nsend;
        int fmode;
        int fidx;
        bit tog;
        int frames;
        int len;
        int exp_err;
    } vec_t;

    typedef struct {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic                 sop;
        logic                 eop;
        logic [3:0]           ch;
    } rec_t;

    rec_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_pulses;
    int   err_misal;
    int   stab_err;
    bit   tog_mode = 1'b0;
    int   exp_chan = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    initial begin
        source_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            source_ready = tog_mode ? ~source_ready : 1'b1;
        end
    end

    // Output monitor: collects transfers, counts error pulses and stall-stability violations.
    initial begin
        bit              prev_stall;
        logic [2*DW+6:0] saved;
        logic [2*DW+6:0] now;
        prev_stall = 1'b0;
        saved      = '0;
        forever begin
            @(negedge clk);
            now = {source_valid, source_sop, source_eop, source_channel, source_Re, source_Im};
            if (!aclr_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (now !== saved)) stab_err++;
                if (source_valid && source_ready)
                    q.push_back('{re: source_Re, im: source_Im, sop: source_sop,
                                  eop: source_eop, ch: source_channel});
                if (error) begin
                    err_pulses++;
                    if (!(source_valid && source_sop)) err_misal++;
                end
                prev_stall = source_valid && !source_ready;
                saved      = now;
            end
        end
    end

    task automatic set_data(input int k);
        in_Re = DW'(k + 1);
        in_Im = -DW'(k + 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int                   k;
        int                   guard;
        int                   target;
        int                   fr_err;
        int                   dat_err;
        int                   ch_err;
        int                   g;
        bit                   acc;
        rec_t                 r;
        logic signed [DW-1:0] e;
        tog_mode   = v.tog;
        pow_sel    = 4'(v.pow);
        err_pulses = 0;
        err_misal  = 0;
        stab_err   = 0;
        k          = 0;
        in_valid   = 1'b1;
        set_data(0);
        flush = (v.fmode == 2 && v.fidx == 0);
        guard = 0;
        while (k < v.nsend && guard < 20000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (acc) begin
                if (k == 0 && !v.tog) check($sformatf("v%0d_latency_sop", idx), {30'd0, source_valid, source_sop}, 32'd3);
                if (k == 0 && v.pow_mid != 0) pow_sel = 4'(v.pow_mid);
                k++;
                flush = 1'b0;
                if (v.fmode == 1 && k == v.fidx + 1) begin
                    in_valid = 1'b0;
                    flush    = 1'b1;
                    @(posedge clk);
                    #1;
                    flush = 1'b0;
                    @(negedge clk);
                    check($sformatf("v%0d_pad_in_ready", idx), {31'd0, in_ready}, 32'd0);
                    k = v.nsend;
                end else if (k < v.nsend) begin
                    set_data(k);
                    flush = (v.fmode == 2 && k == v.fidx);
                end
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        check($sformatf("v%0d_input_done", idx), 32'(k >= v.nsend), 32'd1);

        target = v.frames * v.len;
        guard  = 0;
        while (q.size() < target && guard < 20000) begin
            @(posedge clk);
            guard++;
        end
        repeat (6) @(posedge clk);
        #1;
        check($sformatf("v%0d_out_count", idx), 32'(q.size()), 32'(target));

        for (int f = 0; f < v.frames; f++) begin
            fr_err  = 0;
            dat_err = 0;
            ch_err  = 0;
            for (int j = 0; j < v.len; j++) begin
                g = f * v.len + j;
                if (q.size() == 0) begin
                    fr_err++;
                end else begin
                    r = q.pop_front();
                    e = (v.fmode == 1 && g > v.fidx) ? '0 : DW'(g + 1);
                    if (r.sop !== (j == 0) || r.eop !== (j == v.len - 1)) fr_err++;
                    if (r.re !== e || r.im !== -e) dat_err++;
                    if (r.ch !== 4'(exp_chan)) ch_err++;
                end
            end
            check($sformatf("v%0d_f%0d_sop_eop", idx, f), 32'(fr_err), 32'd0);
            check($sformatf("v%0d_f%0d_data", idx, f), 32'(dat_err), 32'd0);
            check($sformatf("v%0d_f%0d_channel%0d", idx, f, exp_chan), 32'(ch_err), 32'd0);
            exp_chan = (exp_chan + 1) % CH;
        end
        q.delete();
        check($sformatf("v%0d_error_pulses", idx), 32'(err_pulses), 32'(v.exp_err));
        check($sformatf("v%0d_error_align", idx), 32'(err_misal), 32'd0);
        check($sformatf("v%0d_stall_stable", idx), 32'(stab_err), 32'd0);
    endtask

    vec_t vecs[9];
    vec_t vr;

    initial begin
        int k;
        int guard;
        bit acc;
        //                pow mid  nsend fm fidx tog fr len   err
        vecs[0] = '{6,   0,  128,  0, 0,  0,  2, 64,   0};
        vecs[1] = '{6,   0,  21,   1, 20, 0,  1, 64,   0};
        vecs[2] = '{6,   0,  64,   0, 0,  1,  1, 64,   0};
        vecs[3] = '{3,   0,  64,   0, 0,  0,  1, 64,   1};
        vecs[4] = '{6,   0,  64,   2, 63, 0,  1, 64,   0};
        vecs[5] = '{6,   0,  1,    1, 0,  1,  1, 64,   0};
        vecs[6] = '{7,   0,  128,  0, 0,  1,  1, 128,  0};
        vecs[7] = '{15,  0,  4096, 0, 0,  0,  1, 4096, 1};
        vecs[8] = '{6,   12, 64,   0, 0,  0,  1, 64,   0};

        aclr_n   = 1'b0;
        pow_sel  = 4'd6;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_Re    = '0;
        in_Im    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {source_valid, source_sop, source_eop, error, in_ready, source_channel},
              32'd0);
        check("reset_data", {4'd0, source_Re, source_Im}, 32'd0);
        @(negedge clk);
        aclr_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset in the middle of a frame, then a clean frame must start at channel 0.
        pow_sel  = 4'd15;
        in_valid = 1'b1;
        k        = 0;
        guard    = 0;
        set_data(0);
        while (k < 101 && guard < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (acc) begin
                k++;
                set_data(k);
            end
        end
        check("midframe_input_done", 32'(k), 32'd101);
        #2;
        aclr_n = 1'b0;
        #1;
        check("midframe_reset_outputs",
              {source_valid, source_sop, source_eop, error, in_ready, source_channel}, 32'd0);
        check("midframe_reset_data", {4'd0, source_Re, source_Im}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        q.delete();
        aclr_n   = 1'b1;
        exp_chan = 0;
        repeat (2) @(posedge clk);
        #1;
        vr = '{6, 0, 64, 0, 0, 0, 1, 64, 0};
        run_vec(vr, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
